// File: rtl/floor_gen.sv
`default_nettype none
// ============================================================================
// Module   : floor_gen
// Brief    : Platform generator/scroller: eight platform slots scrolled on the
//            slime jump schedule, LFSR-placed spawns and a scroll score.
// Revision : 1.0 - initial release
// ============================================================================
module floor_gen #(
    parameter int         SPAWN_GAP = 60,
    parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_vga,
    input  logic        hit_ceiling,
    input  logic [8:0]  time_gap,
    output logic [9:0]  floor_pos_x0,
    output logic [9:0]  floor_pos_x1,
    output logic [9:0]  floor_pos_x2,
    output logic [9:0]  floor_pos_x3,
    output logic [9:0]  floor_pos_x4,
    output logic [9:0]  floor_pos_x5,
    output logic [9:0]  floor_pos_x6,
    output logic [9:0]  floor_pos_x7,
    output logic [9:0]  floor_pos_y0,
    output logic [9:0]  floor_pos_y1,
    output logic [9:0]  floor_pos_y2,
    output logic [9:0]  floor_pos_y3,
    output logic [9:0]  floor_pos_y4,
    output logic [9:0]  floor_pos_y5,
    output logic [9:0]  floor_pos_y6,
    output logic [9:0]  floor_pos_y7,
    output logic [7:0]  enable,
    output logic [15:0] score
);

    localparam logic [6:0] c_spawn_gap = 7'(SPAWN_GAP);
    localparam logic [9:0] c_y_bottom  = 10'd479;
    localparam logic [9:0] c_rst_x [8] = '{10'd300, 10'd120, 10'd460, 10'd200,
                                           10'd540, 10'd40,  10'd360, 10'd0};
    localparam logic [9:0] c_rst_y [8] = '{10'd380, 10'd320, 10'd260, 10'd200,
                                           10'd140, 10'd80,  10'd20,  10'd0};

    logic [6:0]  r_spawn_cnt;
    logic [15:0] r_score;
    logic [9:0]  r_lfsr;

    logic        w_step;
    logic        w_spawn;
    logic [2:0]  w_target;
    logic [9:0]  w_spawn_x;
    logic [7:0]  w_en;
    logic [9:0]  w_x [8];
    logic [9:0]  w_y [8];

    // Scroll on the same thinning schedule the slime would have climbed on
    always_comb begin
        w_step = 1'b0;
        if (hit_ceiling) begin
            if (time_gap >= 9'd1 && time_gap <= 9'd79)
                w_step = 1'b1;
            else if (time_gap >= 9'd80 && time_gap <= 9'd159)
                w_step = ~time_gap[0];
            else if (time_gap >= 9'd160 && time_gap <= 9'd239)
                w_step = (time_gap[1:0] == 2'b00);
            else if (time_gap >= 9'd240 && time_gap <= 9'd319)
                w_step = (time_gap[2:0] == 3'b000);
        end
    end

    always_comb begin
        w_target = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!w_en[i])
                w_target = 3'(i);
        end
    end

    // Eligibility uses registered enables, so a slot retired this tick waits one tick
    assign w_spawn   = (r_spawn_cnt == c_spawn_gap) && (w_en != 8'hFF);
    assign w_spawn_x = {1'b0, r_lfsr[8:0]} + (r_lfsr[9] ? 10'd88 : 10'd0);

    for (genvar i = 0; i < 8; i++) begin : g_slot
        logic [9:0] r_x;
        logic [9:0] r_y;
        logic       r_en;
        logic       w_spawn_here;

        assign w_spawn_here = w_spawn && (w_target == 3'(i));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_x  <= c_rst_x[i];
                r_y  <= c_rst_y[i];
                r_en <= (i != 7);
            end else if (clk_vga) begin
                if (w_spawn_here) begin
                    r_x  <= w_spawn_x;
                    r_y  <= 10'd0;
                    r_en <= 1'b1;
                end else if (w_step && r_en) begin
                    if (r_y == c_y_bottom)
                        r_en <= 1'b0;
                    else
                        r_y <= r_y + 10'd1;
                end
            end
        end

        assign w_x[i]  = r_x;
        assign w_y[i]  = r_y;
        assign w_en[i] = r_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spawn_cnt <= 7'd20;
            r_score     <= 16'd0;
        end else if (clk_vga) begin
            if (w_spawn)
                r_spawn_cnt <= 7'd0;
            else if (w_step && r_spawn_cnt < c_spawn_gap)
                r_spawn_cnt <= r_spawn_cnt + 7'd1;
            if (w_step && r_score != 16'hFFFF)
                r_score <= r_score + 16'd1;
        end
    end

    // Free-running so spawn positions depend on player timing
    always_ff @(posedge clk) begin
        if (rst)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end

    assign floor_pos_x0 = w_x[0];
    assign floor_pos_x1 = w_x[1];
    assign floor_pos_x2 = w_x[2];
    assign floor_pos_x3 = w_x[3];
    assign floor_pos_x4 = w_x[4];
    assign floor_pos_x5 = w_x[5];
    assign floor_pos_x6 = w_x[6];
    assign floor_pos_x7 = w_x[7];
    assign floor_pos_y0 = w_y[0];
    assign floor_pos_y1 = w_y[1];
    assign floor_pos_y2 = w_y[2];
    assign floor_pos_y3 = w_y[3];
    assign floor_pos_y4 = w_y[4];
    assign floor_pos_y5 = w_y[5];
    assign floor_pos_y6 = w_y[6];
    assign floor_pos_y7 = w_y[7];
    assign enable       = w_en;
    assign score        = r_score;

endmodule
`default_nettype wire

// File: tb/tb_floor_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_floor_gen
// Brief    : Directed self-checking bench for floor_gen (default gap and a
//            short-gap instance that can reach the full-and-saturated state).
// Revision : 1.0 - initial release
// ============================================================================
module tb_floor_gen;

    localparam logic [9:0] c_seed = 10'h2A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_vga;
    logic        hit_ceiling;
    logic [8:0]  time_gap;
    logic [9:0]  x  [8];
    logic [9:0]  y  [8];
    logic [7:0]  en;
    logic [15:0] score;
    logic [9:0]  x2 [8];
    logic [9:0]  y2 [8];
    logic [7:0]  en2;
    logic [15:0] score2;

    logic [9:0]  m_lfsr;
    logic [9:0]  lfsr_at_edge;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    floor_gen #(.SPAWN_GAP(60), .LFSR_SEED(c_seed)) dut (
        .clk(clk), .rst(rst), .clk_vga(clk_vga), .hit_ceiling(hit_ceiling), .time_gap(time_gap),
        .floor_pos_x0(x[0]), .floor_pos_x1(x[1]), .floor_pos_x2(x[2]), .floor_pos_x3(x[3]),
        .floor_pos_x4(x[4]), .floor_pos_x5(x[5]), .floor_pos_x6(x[6]), .floor_pos_x7(x[7]),
        .floor_pos_y0(y[0]), .floor_pos_y1(y[1]), .floor_pos_y2(y[2]), .floor_pos_y3(y[3]),
        .floor_pos_y4(y[4]), .floor_pos_y5(y[5]), .floor_pos_y6(y[6]), .floor_pos_y7(y[7]),
        .enable(en), .score(score)
    );

    // Shorter gap lets all eight slots be live while the counter sits saturated
    floor_gen #(.SPAWN_GAP(50), .LFSR_SEED(c_seed)) dut2 (
        .clk(clk), .rst(rst), .clk_vga(clk_vga), .hit_ceiling(hit_ceiling), .time_gap(time_gap),
        .floor_pos_x0(x2[0]), .floor_pos_x1(x2[1]), .floor_pos_x2(x2[2]), .floor_pos_x3(x2[3]),
        .floor_pos_x4(x2[4]), .floor_pos_x5(x2[5]), .floor_pos_x6(x2[6]), .floor_pos_x7(x2[7]),
        .floor_pos_y0(y2[0]), .floor_pos_y1(y2[1]), .floor_pos_y2(y2[2]), .floor_pos_y3(y2[3]),
        .floor_pos_y4(y2[4]), .floor_pos_y5(y2[5]), .floor_pos_y6(y2[6]), .floor_pos_y7(y2[7]),
        .enable(en2), .score(score2)
    );

    always @(posedge clk) begin
        if (rst)
            m_lfsr <= c_seed;
        else
            m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    function automatic logic [9:0] xmap(input logic [9:0] v);
        return {1'b0, v[8:0]} + (v[9] ? 10'd88 : 10'd0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        clk_vga     = 1'b0;
        hit_ceiling = 1'b0;
        time_gap    = 9'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick(input logic hc, input logic [8:0] tg);
        hit_ceiling  = hc;
        time_gap     = tg;
        clk_vga      = 1'b1;
        lfsr_at_edge = m_lfsr;
        @(posedge clk);
        #1;
        clk_vga = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++)
            tick(1'b1, 9'd50);
    endtask

    initial begin
        int          tgs   [14];
        int          exp_y [14];

        // Reset values and idle ticks
        do_reset();
        check("rst_enable", en, 8'h7F);
        check("rst_x0", x[0], 300);
        check("rst_y0", y[0], 380);
        check("rst_x1", x[1], 120);
        check("rst_y6", y[6], 20);
        check("rst_score", score, 0);
        for (int k = 0; k < 100; k++)
            tick(1'b0, 9'd50);
        check("idle_y0", y[0], 380);
        check("idle_enable", en, 8'h7F);
        check("idle_score", score, 0);

        // Jump schedule, including range edges
        tgs   = '{50, 81, 82, 164, 165, 248, 321, 0, 79, 80, 159, 160, 240, 320};
        exp_y = '{381, 381, 382, 383, 383, 384, 384, 384, 385, 386, 386, 387, 388, 388};
        for (int k = 0; k < 14; k++) begin
            tick(1'b1, 9'(tgs[k]));
            check($sformatf("sched_y0_tg%0d", tgs[k]), y[0], exp_y[k]);
        end
        check("sched_score", score, 8);
        hit_ceiling = 1'b1;
        time_gap    = 9'd10;
        clk_vga     = 1'b0;
        @(posedge clk);
        #1;
        check("no_tick_y0", y[0], 388);
        check("no_tick_score", score, 8);

        // First spawn into slot 7
        do_reset();
        steps(40);
        check("pre_spawn_y6", y[6], 60);
        check("pre_spawn_y0", y[0], 420);
        check("pre_spawn_enable", en, 8'h7F);
        tick(1'b0, 9'd50);
        check("spawn_enable", en, 8'hFF);
        check("spawn_y7", y[7], 0);
        check("spawn_x7", x[7], xmap(lfsr_at_edge));
        check("spawn_x7_range", 32'(x[7] <= 10'd599), 1);
        check("spawn_y6_hold", y[6], 60);

        // Retire of slot 0 at the bottom
        do_reset();
        steps(99);
        check("ret_y0_479", y[0], 479);
        check("ret_enable_pre", en, 8'hFF);
        check("ret_y7", y[7], 58);
        check("ret_y6", y[6], 119);
        steps(1);
        check("ret_enable_post", en, 8'hFE);
        check("ret_y0_hold", y[0], 479);
        check("ret_y7_next", y[7], 59);
        check("ret_score", score, 100);

        // Full with saturated counter, then retire on a saturated tick
        do_reset();
        steps(30);
        tick(1'b0, 9'd50);
        check("full_spawn_enable", en2, 8'hFF);
        check("full_spawn_y7", y2[7], 0);
        steps(50);
        check("full_y0", y2[0], 460);
        check("full_enable", en2, 8'hFF);
        steps(19);
        check("sat_enable", en2, 8'hFF);
        check("sat_y0", y2[0], 479);
        check("sat_y7", y2[7], 69);
        steps(1);
        check("sat_retire_enable", en2, 8'hFE);
        check("sat_retire_y0", y2[0], 479);
        tick(1'b0, 9'd50);
        check("respawn_enable", en2, 8'hFF);
        check("respawn_y0", y2[0], 0);
        check("respawn_x0", x2[0], xmap(lfsr_at_edge));
        check("respawn_y7_hold", y2[7], 70);

        // Reset landing on a pending spawn tick
        do_reset();
        steps(40);
        rst         = 1'b1;
        clk_vga     = 1'b1;
        hit_ceiling = 1'b1;
        time_gap    = 9'd50;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        clk_vga     = 1'b0;
        hit_ceiling = 1'b0;
        check("mid_rst_enable", en, 8'h7F);
        check("mid_rst_x0", x[0], 300);
        check("mid_rst_y0", y[0], 380);
        check("mid_rst_x2", x[2], 460);
        check("mid_rst_y2", y[2], 260);
        check("mid_rst_x4", x[4], 540);
        check("mid_rst_y6", y[6], 20);
        check("mid_rst_y7", y[7], 0);
        check("mid_rst_score", score, 0);
        steps(40);
        check("mid_rst_y6_after", y[6], 60);
        tick(1'b0, 9'd50);
        check("mid_rst_spawn_enable", en, 8'hFF);
        check("mid_rst_spawn_x7", x[7], xmap(lfsr_at_edge));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
